ex_mem_stage_skid: RTL and testbench
====================================

// Module: ex_mem_stage_skid
// PURPOSE
// - Parametrised EX->MEM pipeline stage register with valid/ready handshake, stall support and flush.
// - Optional 2-entry skid buffer so in_ready is registered, breaking the combinational ready path MEM->EX.
// - Replaces fixed per-signal EX/MEM latches; the payload is an opaque packed bus built by the instantiating datapath.
// PARAMETERS
// - PAYLOAD_W   32+32+5+3+3=75 (default 75)  width of in_data/out_data (aluout, writedata, writereg, ctrl, fc).
// - SKID        1    1: 2-entry skid with registered in_ready; 0: single entry, in_ready combinational.
// - RESET_DATA  1    1: payload registers cleared on rst; 0: payload registers are not reset (valid bits always are).
// PORTS
// - clk        in   1          clock, rising edge
// - rst        in   1          synchronous reset, active-high
// - flush      in   1          kill every held entry and any same-cycle input (exception/branch recovery)
// - in_valid   in   1          EX stage presents an instruction
// - in_ready   out  1          stage can accept this cycle
// - in_data    in   PAYLOAD_W  EX payload
// - out_valid  out  1          MEM stage entry valid
// - out_ready  in   1          MEM stage consumes this cycle (deasserted = stall)
// - out_data   out  PAYLOAD_W  MEM payload, always driven from a register
// - occupancy  out  2          number of held entries (0..2; 0..1 when SKID=0)
// BEHAVIOUR
// - Reset (rst=1 at edge): out_valid=0, skid valid=0, occupancy=0; out_data=0 if RESET_DATA; in_ready=1 the cycle after.
// - Transfers: accept = in_valid & in_ready; pop = out_valid & out_ready. Payload never changes while out_valid & !out_ready.
// - Latency: accepted entry appears on out_data/out_valid 1 cycle later (main reg) when main empty or popping.
// - SKID=1 entries: MAIN (drives outputs), SKID (overflow). in_ready = !skid_valid (pure register output).
//   - EMPTY(occ0): accept -> MAIN; occ1.
//   - ONE(occ1): accept&pop -> MAIN<=in_data, occ1; accept&!pop -> SKID<=in_data, occ2; pop only -> occ0.
//   - FULL(occ2): in_ready=0; pop -> MAIN<=SKID, occ1; no pop -> hold.
//   - Order strictly FIFO; SKID never bypasses MAIN.
// - SKID=0: in_ready = !out_valid | out_ready; accept -> MAIN next cycle; pop without accept -> out_valid=0.
// - flush=1: at the edge both valid bits clear, occupancy=0, accept that cycle discarded; flush beats accept and pop.
//   Payload registers may retain stale data (out_valid=0 qualifies). in_ready still follows its rule during flush.
// - flush and rst together: rst wins (identical on valid bits; payload cleared if RESET_DATA).
// - Reset mid-stall: entries discarded, no output pulse; downstream sees out_valid=0 the cycle after the rst edge.
// - X safety: in_data ignored when !in_valid; out_valid never X after first rst edge.
// - Invariants (checked in bench): occupancy<=2; skid_valid -> out_valid; out_data stable while stalled.
// STRUCTURE
// - Shared package cpu_pipe_pkg: EX/MEM payload struct (aluout, writedata, writereg, memtoreg, memwrite, regwrite, fc)
//   and its packed width constant used for PAYLOAD_W.
// - Sub-module pipe_data_reg: PAYLOAD_W-wide register with load enable and optional sync clear (used for MAIN and SKID).
// - Top holds the 2-state-bit occupancy control and mux MAIN<=in_data / MAIN<=SKID.
// TESTING
// - Reset: rst high 2 cycles with in_valid=1 -> out_valid=0, occupancy=0, in_ready=1 after release, out_data=0.
// - Streaming: out_ready=1, 8 back-to-back payloads 0x1..0x8 -> emerge in order 1 cycle later, occupancy stays 1, in_ready=1.
// - Stall fill: out_ready=0, push 0xA,0xB -> occupancy=2, in_ready=0, 0xC held off; release -> 0xA,0xB,0xC in order, no loss/dup.
// - Flush while full: occ2, assert flush with in_valid=1(0xD) -> next cycle out_valid=0, occ0; 0xD never appears.
// - SKID=0 build: out_ready toggling 1/0 each cycle with continuous input -> in_ready equals !out_valid|out_ready each cycle, order kept.
// - Random: 10k cycles random in_valid/out_ready/flush(1%) vs scoreboard model -> exact match, invariants hold.

Source files
------------

// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline definitions: the EX/MEM payload layout and the occupancy
// state encoding used by the stage register.
package cpu_pipe_pkg;

  typedef struct packed {
    logic [31:0] aluout;
    logic [31:0] writedata;
    logic [4:0]  writereg;
    logic        memtoreg;
    logic        memwrite;
    logic        regwrite;
    logic [2:0]  fc;
  } ex_mem_t;

  localparam int unsigned EX_MEM_W = $bits(ex_mem_t);

  // Bit 0 = MAIN valid, bit 1 = SKID valid, so both flags are raw flop outputs.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } occ_e;

  function automatic logic [1:0] occ_count(input occ_e s);
    unique case (s)
      ST_ONE:  occ_count = 2'd1;
      ST_FULL: occ_count = 2'd2;
      default: occ_count = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_data_reg.sv
// Payload register with load enable and optional synchronous clear.
module pipe_data_reg #(
  parameter int unsigned W     = 75,
  parameter bit          CLEAR = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (CLEAR && rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ex_mem_stage_skid.sv
// EX->MEM pipeline stage: valid/ready handshake with stall and flush, plus an
// optional second (skid) entry that makes in_ready a registered signal.
module ex_mem_stage_skid
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned PAYLOAD_W  = EX_MEM_W,
  parameter bit          SKID       = 1'b1,
  parameter bit          RESET_DATA = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_data,
  output logic [1:0]           occupancy
);

  occ_e                 state_q, state_d;
  logic                 skid_valid;
  logic                 accept, pop;
  logic                 main_en, skid_en, main_from_skid;
  logic [PAYLOAD_W-1:0] main_d, skid_q;

  assign out_valid  = state_q[0];
  assign skid_valid = state_q[1];
  assign occupancy  = occ_count(state_q);

  assign in_ready = SKID ? ~skid_valid : (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;
  assign pop      = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    main_en        = 1'b0;
    skid_en        = 1'b0;
    main_from_skid = 1'b0;
    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          main_en = 1'b1;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && pop) begin
          main_en = 1'b1;
        end else if (accept) begin
          // Only reachable with SKID=1: without a skid, accept implies pop here.
          skid_en = 1'b1;
          state_d = ST_FULL;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop) begin
          main_en        = 1'b1;
          main_from_skid = 1'b1;
          state_d        = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) begin
      state_d = ST_EMPTY;
      main_en = 1'b0;
      skid_en = 1'b0;
    end
  end

  assign main_d = main_from_skid ? skid_q : in_data;

  pipe_data_reg #(.W(PAYLOAD_W), .CLEAR(RESET_DATA)) u_main (
    .clk (clk),
    .rst (rst),
    .en  (main_en),
    .d   (main_d),
    .q   (out_data)
  );

  generate
    if (SKID) begin : g_skid
      pipe_data_reg #(.W(PAYLOAD_W), .CLEAR(RESET_DATA)) u_skid (
        .clk (clk),
        .rst (rst),
        .en  (skid_en),
        .d   (in_data),
        .q   (skid_q)
      );
    end else begin : g_noskid
      assign skid_q = '0;
    end
  endgenerate

endmodule

// File: tb/tb_ex_mem_stage_skid.sv
// Directed and randomized checks of ex_mem_stage_skid (SKID=1 and SKID=0 builds).
module tb_ex_mem_stage_skid;
  import cpu_pipe_pkg::*;

  localparam int unsigned W = EX_MEM_W;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready, out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   occupancy;

  logic         flush0 = 1'b0, in_valid0 = 1'b0, out_ready0 = 1'b0;
  logic [W-1:0] in_data0 = '0;
  logic         in_ready0, out_valid0;
  logic [W-1:0] out_data0;
  logic [1:0]   occupancy0;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  ex_mem_stage_skid #(.PAYLOAD_W(W), .SKID(1'b1), .RESET_DATA(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .occupancy(occupancy)
  );

  ex_mem_stage_skid #(.PAYLOAD_W(W), .SKID(1'b0), .RESET_DATA(1'b1)) dut0 (
    .clk(clk), .rst(rst), .flush(flush0), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_data(in_data0), .out_valid(out_valid0), .out_ready(out_ready0),
    .out_data(out_data0), .occupancy(occupancy0)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 75'h5A5; out_ready = 1'b0;
    step();
    step();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    vectors++;
    if (occupancy !== 2'd0) begin
      miscompares++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy);
    end
    rst = 1'b0; in_valid = 1'b0;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    vectors++;
    if (out_data !== '0) begin
      miscompares++; $display("FAIL reset_out_data: got %h expected 0", out_data);
    end
    vectors++;
    if (out_valid0 !== 1'b0 || occupancy0 !== 2'd0) begin
      miscompares++; $display("FAIL reset_skid0: got valid %b occ %0d expected 0 0", out_valid0, occupancy0);
    end
    step();
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = W'(i);
      step();
      vectors++;
      if (out_valid !== 1'b1 || out_data !== W'(i)) begin
        miscompares++; $display("FAIL stream_data[%0d]: got valid %b data %h expected 1 %h", i, out_valid, out_data, W'(i));
      end
      vectors++;
      if (occupancy !== 2'd1 || in_ready !== 1'b1) begin
        miscompares++; $display("FAIL stream_occ[%0d]: got occ %0d ready %b expected 1 1", i, occupancy, in_ready);
      end
    end
    in_valid = 1'b0;
    step();
    vectors++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      miscompares++; $display("FAIL stream_drain: got valid %b occ %0d expected 0 0", out_valid, occupancy);
    end
  endtask

  task automatic test_stall_fill();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = W'('hA);
    step();
    vectors++;
    if (occupancy !== 2'd1 || out_data !== W'('hA)) begin
      miscompares++; $display("FAIL fill_first: got occ %0d data %h expected 1 a", occupancy, out_data);
    end
    in_data = W'('hB);
    step();
    vectors++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== W'('hA)) begin
      miscompares++; $display("FAIL fill_full: got occ %0d ready %b data %h expected 2 0 a", occupancy, in_ready, out_data);
    end
    in_data = W'('hC);
    step();
    vectors++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== W'('hA)) begin
      miscompares++; $display("FAIL fill_hold: got occ %0d ready %b data %h expected 2 0 a", occupancy, in_ready, out_data);
    end
    out_ready = 1'b1;
    step();
    vectors++;
    if (out_valid !== 1'b1 || out_data !== W'('hB) || occupancy !== 2'd1 || in_ready !== 1'b1) begin
      miscompares++; $display("FAIL release_b: got valid %b data %h occ %0d ready %b expected 1 b 1 1", out_valid, out_data, occupancy, in_ready);
    end
    step();
    vectors++;
    if (out_valid !== 1'b1 || out_data !== W'('hC) || occupancy !== 2'd1) begin
      miscompares++; $display("FAIL release_c: got valid %b data %h occ %0d expected 1 c 1", out_valid, out_data, occupancy);
    end
    in_valid = 1'b0;
    step();
    vectors++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      miscompares++; $display("FAIL release_drain: got valid %b occ %0d expected 0 0", out_valid, occupancy);
    end
  endtask

  task automatic test_flush_full();
    out_ready = 1'b0; in_valid = 1'b1; in_data = W'(1);
    step();
    in_data = W'(2);
    step();
    vectors++;
    if (occupancy !== 2'd2) begin
      miscompares++; $display("FAIL flush_setup: got occ %0d expected 2", occupancy);
    end
    in_data = W'('hD); flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    vectors++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin
      miscompares++; $display("FAIL flush_clear: got valid %b occ %0d ready %b expected 0 0 1", out_valid, occupancy, in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (out_valid !== 1'b0) begin
        miscompares++; $display("FAIL flush_no_d[%0d]: got valid %b data %h expected 0", i, out_valid, out_data);
      end
    end
  endtask

  task automatic test_rst_mid_stall();
    out_ready = 1'b0; in_valid = 1'b1; in_data = W'('h77);
    step();
    in_data = W'('h88);
    step();
    rst = 1'b1; flush = 1'b1; in_data = W'('h99);
    step();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    vectors++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_data !== '0) begin
      miscompares++; $display("FAIL rst_stall: got valid %b occ %0d data %h expected 0 0 0", out_valid, occupancy, out_data);
    end
    step();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++; $display("FAIL rst_stall_after: got valid %b expected 0", out_valid);
    end
  endtask

  task automatic test_skid0_toggle();
    logic         m_v = 1'b0;
    logic [W-1:0] m_d = '0;
    logic         exp_ready;
    int unsigned  nxt = 1, exp_pop = 1;
    for (int c = 0; c < 20; c++) begin
      out_ready0 = (c % 2 == 0); in_valid0 = 1'b1; in_data0 = W'(nxt);
      #1;
      exp_ready = ~m_v | out_ready0;
      vectors++;
      if (in_ready0 !== exp_ready) begin
        miscompares++; $display("FAIL skid0_ready[%0d]: got %b expected %b", c, in_ready0, exp_ready);
      end
      vectors++;
      if (out_valid0 !== m_v || (m_v && out_data0 !== m_d)) begin
        miscompares++; $display("FAIL skid0_out[%0d]: got valid %b data %h expected %b %h", c, out_valid0, out_data0, m_v, m_d);
      end
      if (m_v && out_ready0) begin
        vectors++;
        if (out_data0 !== W'(exp_pop)) begin
          miscompares++; $display("FAIL skid0_order[%0d]: got %h expected %h", c, out_data0, W'(exp_pop));
        end
        exp_pop++;
      end
      if (exp_ready) begin
        m_v = 1'b1; m_d = W'(nxt); nxt++;
      end else if (m_v && out_ready0) begin
        m_v = 1'b0;
      end
      step();
    end
    in_valid0 = 1'b0;
  endtask

  task automatic test_random();
    logic [W-1:0] q[$];
    logic [95:0]  r;
    logic         acc;
    for (int c = 0; c < 10000; c++) begin
      vectors++;
      if (occupancy !== 2'(q.size()) || out_valid !== (q.size() > 0)) begin
        miscompares++; $display("FAIL rand_occ[%0d]: got occ %0d valid %b expected %0d", c, occupancy, out_valid, q.size());
      end
      vectors++;
      if (in_ready !== (q.size() < 2)) begin
        miscompares++; $display("FAIL rand_ready[%0d]: got %b expected %b", c, in_ready, q.size() < 2);
      end
      if (q.size() > 0) begin
        vectors++;
        if (out_data !== q[0]) begin
          miscompares++; $display("FAIL rand_data[%0d]: got %h expected %h", c, out_data, q[0]);
        end
      end
      r = {$urandom(), $urandom(), $urandom()};
      in_data   = r[W-1:0];
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      flush     = ($urandom_range(99) == 0);
      acc = in_valid && (q.size() < 2);
      if (flush) begin
        q.delete();
      end else begin
        if (q.size() > 0 && out_ready) void'(q.pop_front());
        if (acc) q.push_back(in_data);
      end
      step();
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_stall_fill();
    test_flush_full();
    test_rst_mid_stall();
    test_skid0_toggle();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
